// File: rtl/tile_skew_feeder.sv
// Diagonal-skew feeder for the systolic MAC tile: one row/column vector per beat in,
// staggered lanes out, sequenced as clear -> K feed beats -> zero drain -> done.

module tile_skew_lane #(
    parameter int W     = 16,
    parameter int DEPTH = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         advance,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    logic [W-1:0] out_d, out_q;

    if (DEPTH == 0) begin : g_direct
        always_comb begin
            out_d = out_q;
            if (clear)
                out_d = '0;
            else if (advance)
                out_d = din;
        end
    end else begin : g_chain
        logic [W-1:0] sr_d [DEPTH];
        logic [W-1:0] sr_q [DEPTH];

        always_comb begin
            sr_d  = sr_q;
            out_d = out_q;
            if (clear) begin
                out_d = '0;
                for (int k = 0; k < DEPTH; k++) sr_d[k] = '0;
            end else if (advance) begin
                out_d   = sr_q[DEPTH-1];
                sr_d[0] = din;
                for (int k = 1; k < DEPTH; k++) sr_d[k] = sr_q[k-1];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < DEPTH; k++) sr_q[k] <= '0;
            end else begin
                sr_q <= sr_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            out_q <= '0;
        else
            out_q <= out_d;
    end

    assign dout = out_q;
endmodule

// state  | meaning
// IDLE   | waiting for start
// CLEAR  | one cycle: tile accumulators and skew chains cleared
// FEED   | accepting k_len beats; each accept advances the array
// DRAIN  | M+N-1 zero advances to flush the diagonal
// DONE   | one-cycle done pulse
module tile_skew_feeder #(
    parameter int M           = 64,
    parameter int N           = 64,
    parameter int INPUT_WIDTH = 16,
    parameter int K_MAX       = 1024,
    localparam int KW         = $clog2(K_MAX + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [KW-1:0]            k_len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [M*INPUT_WIDTH-1:0] in_row,
    input  logic [N*INPUT_WIDTH-1:0] in_col,
    output logic [M*INPUT_WIDTH-1:0] row_out,
    output logic [N*INPUT_WIDTH-1:0] col_out,
    output logic                     mac_enb,
    output logic                     mac_rst,
    output logic                     busy,
    output logic                     done
);
    localparam int W  = INPUT_WIDTH;
    localparam int DW = $clog2(M + N);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(M + N - 2);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state_d, state_q;
    logic [KW-1:0] k_len_d, k_len_q;
    logic [KW-1:0] beat_d, beat_q;
    logic [DW-1:0] drain_d, drain_q;
    logic          mac_enb_d, mac_enb_q;
    logic          mac_rst_d, mac_rst_q;
    logic          done_d, done_q;
    logic          feeding, advance, clear;

    assign feeding  = (state_q == S_FEED);
    assign advance  = (feeding && in_valid) || (state_q == S_DRAIN);
    assign clear    = (state_q == S_CLEAR);
    assign in_ready = feeding;
    assign busy     = (state_q != S_IDLE);

    always_comb begin
        state_d   = state_q;
        k_len_d   = k_len_q;
        beat_d    = beat_q;
        drain_d   = drain_q;
        mac_rst_d = 1'b0;
        done_d    = 1'b0;
        mac_enb_d = advance;
        case (state_q)
            S_IDLE: if (start) begin
                k_len_d = k_len;
                beat_d  = '0;
                drain_d = '0;
                if (k_len == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d   = S_CLEAR;
                    mac_rst_d = 1'b1;
                end
            end
            S_CLEAR: state_d = S_FEED;
            S_FEED: if (in_valid) begin
                if (beat_q == k_len_q - KW'(1)) begin
                    beat_d  = '0;
                    state_d = S_DRAIN;
                end else begin
                    beat_d = beat_q + KW'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    drain_d = '0;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            k_len_q   <= '0;
            beat_q    <= '0;
            drain_q   <= '0;
            mac_enb_q <= 1'b0;
            mac_rst_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_len_q   <= k_len_d;
            beat_q    <= beat_d;
            drain_q   <= drain_d;
            mac_enb_q <= mac_enb_d;
            mac_rst_q <= mac_rst_d;
            done_q    <= done_d;
        end
    end

    assign mac_enb = mac_enb_q;
    assign mac_rst = mac_rst_q;
    assign done    = done_q;

    // Lanes inject zeros whenever not feeding, so drain advances push zeros through.
    for (genvar i = 0; i < M; i++) begin : g_row
        tile_skew_lane #(.W(W), .DEPTH(i)) u_lane (
            .clk(clk), .rst(rst), .clear(clear), .advance(advance),
            .din(feeding ? in_row[i*W +: W] : '0),
            .dout(row_out[i*W +: W])
        );
    end

    for (genvar j = 0; j < N; j++) begin : g_col
        tile_skew_lane #(.W(W), .DEPTH(j)) u_lane (
            .clk(clk), .rst(rst), .clear(clear), .advance(advance),
            .din(feeding ? in_col[j*W +: W] : '0),
            .dout(col_out[j*W +: W])
        );
    end
endmodule

// File: tb/tb_tile_skew_feeder.sv
// Directed bench for tile_skew_feeder: 2x2 cycle-exact vectors plus a 4x4 instance
// driving a behavioural systolic tile checked against A x B.

module tb_tile_skew_feeder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        start2, in_valid2, in_ready2, mac_enb2, mac_rst2, busy2, done2;
    logic [4:0]  k_len2;
    logic [15:0] in_row2, in_col2, row_out2, col_out2;

    logic        start4, in_valid4, in_ready4, mac_enb4, mac_rst4, busy4, done4;
    logic [4:0]  k_len4;
    logic [63:0] in_row4, in_col4, row_out4, col_out4;

    tile_skew_feeder #(.M(2), .N(2), .INPUT_WIDTH(8), .K_MAX(16)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .k_len(k_len2),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .in_row(in_row2), .in_col(in_col2),
        .row_out(row_out2), .col_out(col_out2),
        .mac_enb(mac_enb2), .mac_rst(mac_rst2), .busy(busy2), .done(done2)
    );

    tile_skew_feeder #(.M(4), .N(4), .INPUT_WIDTH(16), .K_MAX(16)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .k_len(k_len4),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .in_row(in_row4), .in_col(in_col4),
        .row_out(row_out4), .col_out(col_out4),
        .mac_enb(mac_enb4), .mac_rst(mac_rst4), .busy(busy4), .done(done4)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural systolic tile: rows flow right, columns flow down.
    logic [15:0] ah [4][4];
    logic [15:0] bv [4][4];
    logic [47:0] acc [4][4];
    int          rst_pulses = 0;

    always @(posedge clk) begin
        if (mac_rst4) begin
            rst_pulses++;
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    ah[i][j]  = '0;
                    bv[i][j]  = '0;
                    acc[i][j] = '0;
                end
        end else if (mac_enb4) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 3; j > 0; j--) ah[i][j] = ah[i][j-1];
                ah[i][0] = row_out4[i*16 +: 16];
            end
            for (int j = 0; j < 4; j++) begin
                for (int i = 3; i > 0; i--) bv[i][j] = bv[i-1][j];
                bv[0][j] = col_out4[j*16 +: 16];
            end
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    acc[i][j] = acc[i][j] + 48'(ah[i][j]) * 48'(bv[i][j]);
        end
    end

    // 2x2 pass, k_len=2, a0=(1,2)/b0=(3,4), a1=(5,6)/b1=(7,8); s stall cycles between beats,
    // spur adds start pulses during FEED and DRAIN carrying a different k_len.
    task automatic run_2x2(input int s, input bit spur, input string nm);
        logic [15:0] e_row, e_col;
        for (int c = 0; c <= 8 + s; c++) begin
            if (c == 3 || (c >= 4 && c <= 3 + s)) begin
                e_row = 16'h0001; e_col = 16'h0003;
            end else if (c == 4 + s) begin
                e_row = 16'h0205; e_col = 16'h0407;
            end else if (c == 5 + s) begin
                e_row = 16'h0600; e_col = 16'h0800;
            end else begin
                e_row = 16'h0000; e_col = 16'h0000;
            end
            if (c >= 1) begin
                chk($sformatf("%s_row_c%0d", nm, c), row_out2, e_row);
                chk($sformatf("%s_col_c%0d", nm, c), col_out2, e_col);
                chk($sformatf("%s_enb_c%0d", nm, c), mac_enb2,
                    c == 3 || (c >= 4 + s && c <= 7 + s));
                chk($sformatf("%s_mrst_c%0d", nm, c), mac_rst2, c == 1);
                chk($sformatf("%s_rdy_c%0d", nm, c), in_ready2, c >= 2 && c <= 3 + s);
                chk($sformatf("%s_done_c%0d", nm, c), done2, c == 7 + s);
            end
            chk($sformatf("%s_busy_c%0d", nm, c), busy2, c >= 1 && c <= 7 + s);
            start2    = (c == 0) || (spur && (c == 2 || c == 5));
            k_len2    = (c == 0) ? 5'd2 : 5'd1;
            in_valid2 = (c == 1) || (c == 2) || (c == 3 + s);
            in_row2   = (c == 3 + s) ? 16'h0605 : (c <= 2) ? 16'h0201 : 16'hBEEF;
            in_col2   = (c == 3 + s) ? 16'h0807 : (c <= 2) ? 16'h0403 : 16'hDEAD;
            tick();
        end
        start2 = 1'b0; in_valid2 = 1'b0;
    endtask

    task automatic run_4x4(input int p);
        logic [15:0] a [7][4];
        logic [15:0] b [7][4];
        logic [47:0] ref_v;
        int beat, cyc, r0;
        bit took;
        for (int k = 0; k < 7; k++)
            for (int l = 0; l < 4; l++) begin
                a[k][l] = 16'($urandom);
                b[k][l] = 16'($urandom);
            end
        r0 = rst_pulses;
        start4 = 1'b1; k_len4 = 5'd7;
        tick();
        start4 = 1'b0; k_len4 = 5'd3;
        beat = 0; cyc = 0;
        while (!done4 && cyc < 200) begin
            if (in_ready4 && beat < 7) begin
                in_valid4 = ($urandom_range(0, 3) != 0);
                for (int l = 0; l < 4; l++) begin
                    in_row4[l*16 +: 16] = a[beat][l];
                    in_col4[l*16 +: 16] = b[beat][l];
                end
            end else begin
                in_valid4 = 1'b0;
                in_row4 = 64'hFFFF_FFFF_FFFF_FFFF;
                in_col4 = 64'hFFFF_FFFF_FFFF_FFFF;
            end
            took = in_valid4 && in_ready4;
            tick();
            if (took) beat++;
            cyc++;
        end
        in_valid4 = 1'b0;
        chk($sformatf("p%0d_done_seen", p), done4, 1'b1);
        chk($sformatf("p%0d_beats", p), beat, 7);
        tick();
        chk($sformatf("p%0d_idle", p), busy4, 1'b0);
        chk($sformatf("p%0d_mac_rst_cnt", p), rst_pulses - r0, 1);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ref_v = '0;
                for (int k = 0; k < 7; k++) ref_v = ref_v + 48'(a[k][i]) * 48'(b[k][j]);
                chk($sformatf("p%0d_acc%0d%0d", p, i, j), acc[i][j], ref_v);
            end
    endtask

    initial begin
        rst = 1'b1;
        start2 = 1'b0; in_valid2 = 1'b0; k_len2 = '0; in_row2 = '0; in_col2 = '0;
        start4 = 1'b0; in_valid4 = 1'b0; k_len4 = '0; in_row4 = '0; in_col4 = '0;
        tick(); tick(); tick();
        rst = 1'b0;
        chk("rst_row", row_out2, 16'h0);
        chk("rst_busy", busy2, 1'b0);
        chk("rst_rdy", in_ready2, 1'b0);
        chk("rst_enb_mrst_done", {mac_enb2, mac_rst2, done2}, 3'b000);
        tick();

        run_2x2(0, 1'b0, "base");
        run_2x2(3, 1'b0, "stall");
        run_2x2(0, 1'b1, "spur");

        // k_len = 0: straight to DONE
        start2 = 1'b1; k_len2 = 5'd0;
        tick();
        start2 = 1'b0;
        chk("k0_busy_c1", busy2, 1'b1);
        chk("k0_done_c1", done2, 1'b1);
        chk("k0_mrst_c1", mac_rst2, 1'b0);
        chk("k0_enb_c1", mac_enb2, 1'b0);
        tick();
        chk("k0_busy_c2", busy2, 1'b0);
        chk("k0_done_c2", done2, 1'b0);
        chk("k0_enb_c2", mac_enb2, 1'b0);

        // reset held 2 cycles mid-FEED
        start2 = 1'b1; k_len2 = 5'd2;
        tick();
        start2 = 1'b0; in_valid2 = 1'b1; in_row2 = 16'h0201; in_col2 = 16'h0403;
        tick();
        tick();
        chk("mid_rdy_pre", in_ready2, 1'b1);
        chk("mid_enb_pre", mac_enb2, 1'b1);
        rst = 1'b1; in_row2 = 16'h0605; in_col2 = 16'h0807;
        tick();
        for (int c = 0; c < 3; c++) begin
            if (c == 1) rst = 1'b0;
            chk($sformatf("mrst_row_%0d", c), row_out2, 16'h0);
            chk($sformatf("mrst_col_%0d", c), col_out2, 16'h0);
            chk($sformatf("mrst_ctl_%0d", c),
                {mac_enb2, mac_rst2, done2, busy2, in_ready2}, 5'b00000);
            tick();
        end
        in_valid2 = 1'b0;
        tick();

        run_2x2(0, 1'b0, "post");

        for (int p = 0; p < 3; p++) run_4x4(p);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
